// File: rtl/pipeline_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl_if
// Description : Hazard inputs and stage-control outputs of the RV32I
//               pipeline stall/flush controller, bundled as one interface.
//               The master side raises hazards and observes the controls.
//               The slave side is the controller itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_ctrl_if #(
  parameter int CNT_WIDTH = 32
);
  // Hazard sources
  logic                 load_use_stall_i;
  logic                 branch_taken_i;
  logic                 ex_busy_i;
  logic                 mem_busy_i;

  // Per-stage register controls
  logic                 pc_en_o;
  logic                 if_id_en_o;
  logic                 if_id_flush_o;
  logic                 id_ex_en_o;
  logic                 id_ex_flush_o;
  logic                 ex_mem_en_o;
  logic                 ex_mem_flush_o;
  logic                 mem_wb_en_o;

  // Debug view
  logic [1:0]           state_o;
  logic [CNT_WIDTH-1:0] stall_cnt_o;
  logic [CNT_WIDTH-1:0] flush_cnt_o;

  // Hazard producers / control consumers
  modport master (
    output load_use_stall_i, branch_taken_i, ex_busy_i, mem_busy_i,
    input  pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o, id_ex_flush_o,
           ex_mem_en_o, ex_mem_flush_o, mem_wb_en_o,
           state_o, stall_cnt_o, flush_cnt_o
  );

  // The controller
  modport slave (
    input  load_use_stall_i, branch_taken_i, ex_busy_i, mem_busy_i,
    output pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o, id_ex_flush_o,
           ex_mem_en_o, ex_mem_flush_o, mem_wb_en_o,
           state_o, stall_cnt_o, flush_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Central stall/flush controller for the 5-stage RV32I
//               pipeline. Merges load-use stall, EX redirect, multi-cycle
//               EX busy and data-memory wait into per-stage enables and
//               bubble controls. A redirect seen while frozen is latched
//               and applied once the pipeline advances. Saturating stall
//               and flush counters feed the debug view.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl #(
  parameter int CNT_WIDTH = 32
) (
  input  wire              clk_i,
  input  wire              rst_i,
  pipeline_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FREEZE  = 2'd1,
    ST_EX_WAIT = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] c_cnt_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Registered state
  state_t               r_state;
  logic                 r_flush_pending;
  logic [CNT_WIDTH-1:0] r_stall_cnt;
  logic [CNT_WIDTH-1:0] r_flush_cnt;

  // Combinational controls
  logic w_redir;
  logic w_redir_apply;
  logic w_pc_en;
  logic w_if_id_en;
  logic w_if_id_flush;
  logic w_id_ex_en;
  logic w_id_ex_flush;
  logic w_ex_mem_en;
  logic w_ex_mem_flush;
  logic w_mem_wb_en;

  // A latched redirect counts exactly like a fresh pulse
  assign w_redir = bus.branch_taken_i | r_flush_pending;

  // The redirect only takes effect when nothing is holding the pipeline
  assign w_redir_apply = !rst_i && !bus.mem_busy_i && !bus.ex_busy_i && w_redir;

  // Priority decode of the stage enables and bubble controls
  always_comb begin
    w_pc_en        = 1'b1;
    w_if_id_en     = 1'b1;
    w_if_id_flush  = 1'b0;
    w_id_ex_en     = 1'b1;
    w_id_ex_flush  = 1'b0;
    w_ex_mem_en    = 1'b1;
    w_ex_mem_flush = 1'b0;
    w_mem_wb_en    = 1'b1;
    if (rst_i) begin
      // Hold every register and push NOPs into the front three
      w_pc_en        = 1'b0;
      w_if_id_en     = 1'b0;
      w_id_ex_en     = 1'b0;
      w_ex_mem_en    = 1'b0;
      w_mem_wb_en    = 1'b0;
      w_if_id_flush  = 1'b1;
      w_id_ex_flush  = 1'b1;
      w_ex_mem_flush = 1'b1;
    end else if (bus.mem_busy_i) begin
      // Full freeze: nothing moves and nothing is squashed
      w_pc_en     = 1'b0;
      w_if_id_en  = 1'b0;
      w_id_ex_en  = 1'b0;
      w_ex_mem_en = 1'b0;
      w_mem_wb_en = 1'b0;
    end else if (bus.ex_busy_i) begin
      // Front held, bubble behind EX so older instructions drain
      w_pc_en        = 1'b0;
      w_if_id_en     = 1'b0;
      w_id_ex_en     = 1'b0;
      w_ex_mem_flush = 1'b1;
    end else if (w_redir) begin
      // Wrong-path instructions in IF/ID and ID/EX are squashed; a
      // simultaneous load-use stall is moot since its victim is squashed
      w_if_id_flush = 1'b1;
      w_id_ex_flush = 1'b1;
    end else if (bus.load_use_stall_i) begin
      // Hold the front, insert a bubble into EX
      w_pc_en       = 1'b0;
      w_if_id_en    = 1'b0;
      w_id_ex_flush = 1'b1;
    end
  end

  // Controller state and the pending-redirect latch
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state         <= ST_RUN;
      r_flush_pending <= 1'b0;
    end else begin
      if (bus.mem_busy_i) begin
        r_state <= ST_FREEZE;
      end else if (bus.ex_busy_i) begin
        r_state <= ST_EX_WAIT;
      end else begin
        r_state <= ST_RUN;
      end

      // Set and clear are mutually exclusive: the clear needs both busies low
      if (bus.branch_taken_i && (bus.mem_busy_i || bus.ex_busy_i)) begin
        r_flush_pending <= 1'b1;
      end else if (w_redir_apply) begin
        r_flush_pending <= 1'b0;
      end
    end
  end

  // Saturating counters of stalled cycles and applied redirects
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!w_pc_en && !(&r_stall_cnt)) begin
        r_stall_cnt <= r_stall_cnt + c_cnt_one;
      end
      if (w_redir_apply && !(&r_flush_cnt)) begin
        r_flush_cnt <= r_flush_cnt + c_cnt_one;
      end
    end
  end

  assign bus.pc_en_o        = w_pc_en;
  assign bus.if_id_en_o     = w_if_id_en;
  assign bus.if_id_flush_o  = w_if_id_flush;
  assign bus.id_ex_en_o     = w_id_ex_en;
  assign bus.id_ex_flush_o  = w_id_ex_flush;
  assign bus.ex_mem_en_o    = w_ex_mem_en;
  assign bus.ex_mem_flush_o = w_ex_mem_flush;
  assign bus.mem_wb_en_o    = w_mem_wb_en;
  assign bus.state_o        = r_state;
  assign bus.stall_cnt_o    = r_stall_cnt;
  assign bus.flush_cnt_o    = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Self-checking bench for pipeline_ctrl. The driver applies
//               one directed vector per cycle and queues its hand-computed
//               expected outputs. The monitor pops and compares each entry
//               mid-cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

  localparam int CW = 4;

  typedef struct {
    int          id;
    logic [4:0]  en;   // {pc, if_id, id_ex, ex_mem, mem_wb}
    logic [2:0]  fl;   // {if_id, id_ex, ex_mem}
    logic [1:0]  st;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   vec_id;
  bit   drv_done;
  exp_t q[$];

  pipeline_ctrl_if #(.CNT_WIDTH(CW)) bus ();

  pipeline_ctrl #(.CNT_WIDTH(CW)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One vector per cycle: inputs change 1 ns after the rising edge
  task automatic cyc(input logic r, input logic lu, input logic br,
                     input logic ex, input logic mem,
                     input logic [4:0] en, input logic [2:0] fl,
                     input logic [1:0] st, input int sc, input int fc);
    exp_t e;
    @(posedge clk);
    #1;
    rst                  = r;
    bus.load_use_stall_i = lu;
    bus.branch_taken_i   = br;
    bus.ex_busy_i        = ex;
    bus.mem_busy_i       = mem;
    e.id = vec_id;
    e.en = en;
    e.fl = fl;
    e.st = st;
    e.sc = CW'(sc);
    e.fc = CW'(fc);
    q.push_back(e);
    vec_id++;
  endtask

  task automatic chk(input string name, input int id, input logic [31:0] act,
                     input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s vec=%0d actual=%0h required=%0h", name, id, act, req);
    end
  endtask

  // Monitor: compare the oldest expectation against the outputs mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("enables", e.id, 32'({bus.pc_en_o, bus.if_id_en_o, bus.id_ex_en_o,
                                  bus.ex_mem_en_o, bus.mem_wb_en_o}), 32'(e.en));
        chk("flushes", e.id, 32'({bus.if_id_flush_o, bus.id_ex_flush_o,
                                  bus.ex_mem_flush_o}), 32'(e.fl));
        chk("state", e.id, 32'(bus.state_o), 32'(e.st));
        chk("stall_cnt", e.id, 32'(bus.stall_cnt_o), 32'(e.sc));
        chk("flush_cnt", e.id, 32'(bus.flush_cnt_o), 32'(e.fc));
      end
    end
  end

  // Driver: directed vectors with expectations worked out by hand
  initial begin
    n_checks = 0;
    n_fail   = 0;
    vec_id   = 0;
    drv_done = 1'b0;
    rst = 1'b1;
    bus.load_use_stall_i = 1'b0;
    bus.branch_taken_i   = 1'b0;
    bus.ex_busy_i        = 1'b0;
    bus.mem_busy_i       = 1'b0;

    //   rst lu br ex mem   en        fl      st  sc fc
    cyc(1, 0, 0, 0, 0, 5'b00000, 3'b111, 2'd0, 0, 0);  // reset
    cyc(0, 0, 0, 0, 0, 5'b11111, 3'b000, 2'd0, 0, 0);  // idle
    cyc(0, 0, 0, 0, 0, 5'b11111, 3'b000, 2'd0, 0, 0);
    cyc(0, 1, 0, 0, 0, 5'b00111, 3'b010, 2'd0, 0, 0);  // load-use
    cyc(0, 0, 0, 0, 0, 5'b11111, 3'b000, 2'd0, 1, 0);
    cyc(0, 1, 1, 0, 0, 5'b11111, 3'b110, 2'd0, 1, 0);  // redirect beats load-use
    cyc(0, 0, 0, 0, 0, 5'b11111, 3'b000, 2'd0, 1, 1);
    cyc(0, 0, 1, 0, 1, 5'b00000, 3'b000, 2'd0, 1, 1);  // freeze + branch latched
    cyc(0, 0, 0, 0, 1, 5'b00000, 3'b000, 2'd1, 2, 1);
    cyc(0, 0, 0, 0, 1, 5'b00000, 3'b000, 2'd1, 3, 1);
    cyc(0, 0, 0, 0, 0, 5'b11111, 3'b110, 2'd1, 4, 1);  // pending redirect applied
    cyc(0, 0, 0, 0, 0, 5'b11111, 3'b000, 2'd0, 4, 2);  // pending cleared
    cyc(0, 0, 0, 1, 0, 5'b00011, 3'b001, 2'd0, 4, 2);  // ex busy x4
    cyc(0, 0, 0, 1, 0, 5'b00011, 3'b001, 2'd2, 5, 2);
    cyc(0, 0, 0, 1, 0, 5'b00011, 3'b001, 2'd2, 6, 2);
    cyc(0, 0, 0, 1, 0, 5'b00011, 3'b001, 2'd2, 7, 2);
    cyc(0, 0, 0, 0, 0, 5'b11111, 3'b000, 2'd2, 8, 2);
    cyc(0, 0, 1, 0, 0, 5'b11111, 3'b110, 2'd0, 8, 2);  // back-to-back redirects
    cyc(0, 0, 1, 0, 0, 5'b11111, 3'b110, 2'd0, 8, 3);
    cyc(0, 0, 0, 0, 0, 5'b11111, 3'b000, 2'd0, 8, 4);
    cyc(0, 0, 1, 1, 0, 5'b00011, 3'b001, 2'd0, 8, 4);  // branch during ex busy
    cyc(0, 0, 0, 0, 0, 5'b11111, 3'b110, 2'd2, 9, 4);
    cyc(0, 0, 0, 0, 0, 5'b11111, 3'b000, 2'd0, 9, 5);
    cyc(0, 0, 1, 0, 1, 5'b00000, 3'b000, 2'd0, 9, 5);  // latch, then reset
    cyc(1, 0, 0, 0, 1, 5'b00000, 3'b111, 2'd1, 10, 5);
    cyc(0, 0, 0, 0, 0, 5'b11111, 3'b000, 2'd0, 0, 0);  // pending discarded
    // Long load-use hold drives stall_cnt into saturation at 15
    for (int k = 0; k < 20; k++) begin
      cyc(0, 1, 0, 0, 0, 5'b00111, 3'b010, 2'd0, (k > 15) ? 15 : k, 0);
    end
    cyc(0, 0, 0, 0, 0, 5'b11111, 3'b000, 2'd0, 15, 0);
    cyc(1, 0, 0, 0, 0, 5'b00000, 3'b111, 2'd0, 15, 0);
    cyc(0, 0, 0, 0, 0, 5'b11111, 3'b000, 2'd0, 0, 0);
    // mem_busy outranks ex_busy, which outranks load-use
    cyc(0, 1, 0, 1, 1, 5'b00000, 3'b000, 2'd0, 0, 0);
    cyc(0, 1, 0, 1, 0, 5'b00011, 3'b001, 2'd1, 1, 0);
    cyc(0, 0, 0, 0, 0, 5'b11111, 3'b000, 2'd2, 2, 0);

    drv_done = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain actual=%0d required=0 pending entries", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound in case the driver stalls
  initial begin
    #50000;
    if (!drv_done) begin
      n_fail++;
      $display("FAIL timeout actual=%0d required=done vectors", vec_id);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "timeout");
    end
  end

endmodule
`default_nettype wire

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush controller for the 5-stage RV32I pipeline. It combines the decode-stage load-use stall request, the EX-stage branch/jump redirect, a multi-cycle EX busy and a data-memory wait into one consistent set of per-stage register enables and bubble/flush controls. A redirect that arrives while the pipeline is frozen is held until the pipeline advances. It also keeps saturating stall and flush counters for the didactic debug view.

## Interface
- CNT_WIDTH, 32, width of the stall and flush counters
- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  synchronous, active-high reset
- load_use_stall_i  input  1  load-use hazard from the decode stall logic
- branch_taken_i  input  1  EX-stage redirect (taken branch, JAL, JALR); one pulse per redirect
- ex_busy_i  input  1  multi-cycle EX operation not finished
- mem_busy_i  input  1  data memory not ready; whole pipeline must hold
- pc_en_o  output  1  PC register load enable
- if_id_en_o  output  1  IF/ID register enable
- if_id_flush_o  output  1  IF/ID loads a NOP
- id_ex_en_o  output  1  ID/EX register enable
- id_ex_flush_o  output  1  ID/EX loads a bubble (write and memory controls cleared)
- ex_mem_en_o  output  1  EX/MEM register enable
- ex_mem_flush_o  output  1  EX/MEM loads a bubble
- mem_wb_en_o  output  1  MEM/WB register enable
- state_o  output  2  controller state: RUN=0, FREEZE=1, EX_WAIT=2
- stall_cnt_o  output  CNT_WIDTH  cycles with pc_en_o=0 outside reset
- flush_cnt_o  output  CNT_WIDTH  number of redirect flushes applied

## Operation
- Registered state: state (2 b), flush_pending (1 b), stall_cnt, flush_cnt. Enables and flushes are combinational from the inputs and the registered state.
- Effective redirect: redir = branch_taken_i | flush_pending.
- Priority, highest first:
  - rst_i: all *_en_o=0, if_id_flush_o=id_ex_flush_o=ex_mem_flush_o=1.
  - mem_busy_i: all enables 0 and all flushes 0 (full freeze).
  - ex_busy_i: pc_en_o=if_id_en_o=id_ex_en_o=0. ex_mem_en_o=1 with ex_mem_flush_o=1. mem_wb_en_o=1, so older instructions drain.
  - redir: all enables 1, if_id_flush_o=id_ex_flush_o=1. This overrides load_use_stall_i because the stalled instruction is on the wrong path.
  - load_use_stall_i: pc_en_o=if_id_en_o=0, id_ex_en_o=1 with id_ex_flush_o=1. EX/MEM and MEM/WB are enabled.
  - Otherwise: all enables 1, all flushes 0.
- flush_pending:
  - Set when branch_taken_i=1 while mem_busy_i or ex_busy_i is 1.
  - Cleared in the cycle where redir is applied (no freeze, no ex_busy).
  - Set and clear never coincide.
  - branch_taken_i with ex_busy_i is a protocol violation. It is still latched, never dropped.
- State next value: mem_busy_i → FREEZE; else ex_busy_i → EX_WAIT; else RUN. Reset → RUN.
- stall_cnt increments when pc_en_o=0 and rst_i=0. flush_cnt increments when redir is applied. Both saturate at all-ones and do not wrap.

## Timing
- Zero-latency control: outputs reflect the current-cycle inputs. A pending redirect is applied in the first cycle with mem_busy_i=0 and ex_busy_i=0 after it was latched, i.e. at least one cycle after the pulse.
- Reset values, after the edge with rst_i=1: state_o=0, flush_pending=0, stall_cnt_o=0, flush_cnt_o=0. Combinational outputs follow the reset rule while rst_i is high.
- Reset asserted mid-freeze or with a flush pending discards the pending flush. The first cycle after reset is plain RUN.
- Two back-to-back redirect pulses with no freeze each flush independently. flush_cnt advances by 2.
- A load-use stall lasts exactly as long as load_use_stall_i is high. Normally this is one cycle, because the bubble then clears the hazard.

## Test plan
- Reset, then idle with all inputs 0 → all enables 1, all flushes 0, state_o=0, both counters 0.
- Load-use stall held 1 cycle → pc_en_o=if_id_en_o=0 and id_ex_flush_o=1 for that cycle. stall_cnt_o=1 afterwards.
- branch_taken_i and load_use_stall_i in the same cycle → if_id_flush_o=id_ex_flush_o=1, pc_en_o=1, flush_cnt_o=1, stall_cnt_o unchanged.
- mem_busy_i high 3 cycles with branch_taken_i pulsed in the first of them:
  - during the 3 cycles, all enables 0, state_o=1, stall_cnt_o advances by 3;
  - in the next cycle, redirect flush is applied (if_id_flush_o=id_ex_flush_o=1) and flush_pending clears.
- ex_busy_i high 4 cycles → state_o=2, ex_mem_flush_o=1, mem_wb_en_o=1, front stages held. stall_cnt_o advances by 4.
- Counter saturation (preload via long stall with CNT_WIDTH=4) → stall_cnt_o stops at 15. rst_i then clears it to 0.
